// File: rtl/ow_pkg.sv
// Shared definitions for the 1-Wire temperature slave: command codes, FSM states,
// bus timing in 1 us ticks and the fixed scratchpad bytes.
package ow_pkg;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ_SP  = 8'hBE;

    localparam logic [7:0] T_PRES_WAIT_US = 8'd30;
    localparam logic [7:0] T_PRES_DRV_US  = 8'd120;
    localparam logic [7:0] T_SAMPLE_US    = 8'd30;
    localparam logic [7:0] T_TX_DRV_US    = 8'd45;

    localparam logic [15:0] SP_TEMP_DEFAULT = 16'h0550;
    localparam logic [7:0]  SP_B2 = 8'h4B;
    localparam logic [7:0]  SP_B3 = 8'h46;
    localparam logic [7:0]  SP_B4 = 8'h7F;
    localparam logic [7:0]  SP_B5 = 8'hFF;
    localparam logic [7:0]  SP_B6 = 8'h0C;
    localparam logic [7:0]  SP_B7 = 8'h10;

    typedef enum logic [2:0] {
        IDLE,
        PRES_WAIT,
        PRES_DRV,
        ROM_CMD,
        FUNC_CMD,
        TX_DATA,
        DONE
    } ow_state_e;

endpackage

// File: rtl/ow_crc8.sv
// Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, init 0x00) over eight bytes, byte 0 in
// data_i[7:0], every byte consumed LSB first.
module ow_crc8 (
    input  logic [63:0] data_i,
    output logic [7:0]  crc_o
);

    logic [7:0] crc;
    logic       fb;

    always_comb begin
        crc = 8'h00;
        fb  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            fb  = crc[0] ^ data_i[i];
            crc = crc >> 1;
            if (fb) begin
                crc = crc ^ 8'h8C;
            end
        end
        crc_o = crc;
    end

endmodule

// File: rtl/onewire_temp_slave.sv
// 1-Wire temperature sensor slave (SKIP ROM, CONVERT T, READ SCRATCHPAD).
// Define OW_SLAVE_CRC_EN to append the CRC-8 byte 8 to the scratchpad.
//
// state     | meaning
// IDLE      | bus idle, waiting for a reset pulse
// PRES_WAIT | reset seen, dq released before the presence pulse
// PRES_DRV  | presence pulse, dq driven low
// ROM_CMD   | receiving the ROM command byte
// FUNC_CMD  | receiving the function command byte
// TX_DATA   | answering read slots with scratchpad bits
// DONE      | transaction finished; read slots answer conversion status
module onewire_temp_slave
    import ow_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int RST_MIN_US   = 480,
    parameter int CONV_US      = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire         dq,
    input  logic [15:0] temp_in,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        conv_busy
);

    localparam logic [7:0]  DIV_LOAD  = 8'(CLK_FREQ_MHZ - 1);
    localparam logic [15:0] RST_MIN   = 16'(RST_MIN_US);
    localparam logic [15:0] CONV_LOAD = 16'(CONV_US);

    ow_state_e   state_q, state_d;
    logic        dq_s1_q, dq_s1_d, dq_s2_q, dq_s2_d, dq_prev_q, dq_prev_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] low_q, low_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [15:0] conv_q, conv_d;
    logic        drive_q, drive_d;
    logic        slot_q, slot_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] temp_q, temp_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        cmd_valid_q, cmd_valid_d;

    logic        tick, fall, rise, bus_rst, tmr_done, busy;
    logic [7:0]  rx_byte, sp_byte;

    assign dq        = drive_q ? 1'b0 : 1'bz;
    assign cmd_byte  = cmd_byte_q;
    assign cmd_valid = cmd_valid_q;
    assign conv_busy = busy;

`ifdef OW_SLAVE_CRC_EN
    logic [7:0] crc_w;

    ow_crc8 u_crc8 (
        .data_i ({SP_B7, SP_B6, SP_B5, SP_B4, SP_B3, SP_B2, temp_q}),
        .crc_o  (crc_w)
    );
`endif

    always_comb begin
        dq_s1_d   = dq;
        dq_s2_d   = dq_s1_q;
        dq_prev_d = dq_s2_q;
        tick      = (div_q == 8'd0);
        div_d     = tick ? DIV_LOAD : div_q - 8'd1;
        fall      = dq_prev_q & ~dq_s2_q;
        rise      = ~dq_prev_q & dq_s2_q;
        // Low-time saturates at the threshold so a long hold cannot wrap.
        low_d = low_q;
        if (dq_s2_q) begin
            low_d = '0;
        end else if (tick && (low_q != RST_MIN)) begin
            low_d = low_q + 16'd1;
        end
        bus_rst  = (low_q >= RST_MIN);
        tmr_done = tick && (tmr_q == 8'd1);
        busy     = (conv_q != 16'd0);
        rx_byte  = {dq_s2_q, sh_q[7:1]};
    end

    always_comb begin
        case (byte_idx_q)
            4'd0:    sp_byte = temp_q[7:0];
            4'd1:    sp_byte = temp_q[15:8];
            4'd2:    sp_byte = SP_B2;
            4'd3:    sp_byte = SP_B3;
            4'd4:    sp_byte = SP_B4;
            4'd5:    sp_byte = SP_B5;
            4'd6:    sp_byte = SP_B6;
            4'd7:    sp_byte = SP_B7;
`ifdef OW_SLAVE_CRC_EN
            4'd8:    sp_byte = crc_w;
`endif
            default: sp_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        drive_d     = drive_q;
        slot_d      = slot_q;
        tmr_d       = tmr_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        temp_d      = temp_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        conv_d      = conv_q;
        if (tick && (tmr_q != 8'd0)) begin
            tmr_d = tmr_q - 8'd1;
        end
        // The conversion counter is independent of the bus FSM and survives bus resets.
        if (tick && busy) begin
            conv_d = conv_q - 16'd1;
        end

        if (bus_rst) begin
            drive_d   = 1'b0;
            slot_d    = 1'b0;
            tmr_d     = 8'd0;
            bit_cnt_d = 3'd0;
            if (rise) begin
                state_d = PRES_WAIT;
                tmr_d   = T_PRES_WAIT_US;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                end
                PRES_WAIT: begin
                    if (tmr_done) begin
                        state_d = PRES_DRV;
                        drive_d = 1'b1;
                        tmr_d   = T_PRES_DRV_US;
                    end
                end
                PRES_DRV: begin
                    if (tmr_done) begin
                        state_d   = ROM_CMD;
                        drive_d   = 1'b0;
                        slot_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                    end
                end
                ROM_CMD, FUNC_CMD: begin
                    if (!slot_q && fall) begin
                        slot_d = 1'b1;
                        tmr_d  = T_SAMPLE_US;
                    end else if (slot_q && tmr_done) begin
                        slot_d    = 1'b0;
                        sh_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_byte_d  = rx_byte;
                            cmd_valid_d = 1'b1;
                            if (state_q == ROM_CMD) begin
                                state_d = (rx_byte == CMD_SKIP_ROM) ? FUNC_CMD : DONE;
                            end else begin
                                state_d = DONE;
                                if (rx_byte == CMD_CONVERT) begin
                                    temp_d = temp_in;
                                    conv_d = CONV_LOAD;
                                end else if (rx_byte == CMD_READ_SP) begin
                                    state_d    = TX_DATA;
                                    byte_idx_d = 4'd0;
                                    bit_idx_d  = 3'd0;
                                end
                            end
                        end
                    end
                end
                TX_DATA: begin
                    if (!slot_q && fall) begin
                        slot_d    = 1'b1;
                        tmr_d     = T_TX_DRV_US;
                        drive_d   = ~sp_byte[bit_idx_q];
                        bit_idx_d = bit_idx_q + 3'd1;
                        if ((bit_idx_q == 3'd7) && (byte_idx_q != 4'hF)) begin
                            byte_idx_d = byte_idx_q + 4'd1;
                        end
                    end else if (slot_q && tmr_done) begin
                        slot_d  = 1'b0;
                        drive_d = 1'b0;
                    end
                end
                DONE: begin
                    if (!slot_q && fall) begin
                        slot_d  = 1'b1;
                        tmr_d   = T_TX_DRV_US;
                        drive_d = busy;
                    end else if (slot_q && tmr_done) begin
                        slot_d  = 1'b0;
                        drive_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dq_s1_q     <= 1'b1;
            dq_s2_q     <= 1'b1;
            dq_prev_q   <= 1'b1;
            div_q       <= '0;
            low_q       <= '0;
            tmr_q       <= '0;
            conv_q      <= '0;
            drive_q     <= 1'b0;
            slot_q      <= 1'b0;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            byte_idx_q  <= '0;
            bit_idx_q   <= '0;
            temp_q      <= SP_TEMP_DEFAULT;
            cmd_byte_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_s1_q     <= dq_s1_d;
            dq_s2_q     <= dq_s2_d;
            dq_prev_q   <= dq_prev_d;
            div_q       <= div_d;
            low_q       <= low_d;
            tmr_q       <= tmr_d;
            conv_q      <= conv_d;
            drive_q     <= drive_d;
            slot_q      <= slot_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            bit_idx_q   <= bit_idx_d;
            temp_q      <= temp_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

endmodule
